// File: rtl/stdp_rand_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stdp_rand_update: stochastic STDP weight-update engine for one column     |
// | neuron. Optional STDP_WEIGHT_LOAD_EN adds an IDLE-time weight write port. |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module stdp_rand_update #(
  parameter int NSYN   = 8,
  parameter int WBITS  = 3,
  parameter int TBITS  = 4,
  parameter int INIT_W = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NSYN*TBITS-1:0]   in_time,
  input  logic [TBITS-1:0]        out_time,
  input  logic [15:0]             rnd,
  input  logic [15:0]             mu_capture,
  input  logic [15:0]             mu_backoff,
  input  logic [15:0]             mu_search,
  output logic                    busy,
  output logic                    done,
  output logic [NSYN*WBITS-1:0]   weights
`ifdef STDP_WEIGHT_LOAD_EN
  ,
  input  logic                    wr_en,
  input  logic [$clog2(NSYN)-1:0] wr_idx,
  input  logic [WBITS-1:0]        wr_data
`endif
);

  localparam int IDXW = $clog2(NSYN);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSYN - 1);
  localparam logic [WBITS-1:0] INIT_W_C = WBITS'(INIT_W);
  localparam logic [WBITS-1:0] W_MAX    = {WBITS{1'b1}};
  localparam logic [TBITS-1:0] NO_SPIKE = {TBITS{1'b1}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [TBITS-1:0] ti_q [NSYN];
  logic [TBITS-1:0] ti_d [NSYN];
  logic [TBITS-1:0] to_q, to_d;
  logic [WBITS-1:0] w_q [NSYN];
  logic [WBITS-1:0] w_d [NSYN];

  logic             wr_hit;
  logic [IDXW-1:0]  wr_sel;
  logic [WBITS-1:0] wr_val;

`ifdef STDP_WEIGHT_LOAD_EN
  localparam logic [IDXW:0] NSYN_C = (IDXW+1)'(NSYN);
  assign wr_hit = wr_en && ({1'b0, wr_idx} < NSYN_C);
  assign wr_sel = wr_idx;
  assign wr_val = wr_data;
`else
  assign wr_hit = 1'b0;
  assign wr_sel = '0;
  assign wr_val = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_UPDATE;
      ST_UPDATE: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_UPDATE) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
  end

  // Bernoulli draw and saturating step for the synapse selected by idx_q
  logic [TBITS-1:0] ti_cur;
  logic [WBITS-1:0] w_cur, w_new;
  logic             ti_sp, to_sp, inc, dec;

  always_comb begin
    ti_cur = ti_q[idx_q];
    w_cur  = w_q[idx_q];
    ti_sp  = (ti_cur != NO_SPIKE);
    to_sp  = (to_q != NO_SPIKE);
    inc    = 1'b0;
    dec    = 1'b0;
    if (ti_sp && to_sp) begin
      if (ti_cur <= to_q) inc = (rnd < mu_capture);
      else                dec = (rnd < mu_backoff);
    end else if (ti_sp) begin
      inc = (rnd < mu_search);
    end else if (to_sp) begin
      dec = (rnd < mu_backoff);
    end
    w_new = w_cur;
    if (inc && (w_cur != W_MAX))      w_new = w_cur + 1'b1;
    else if (dec && (w_cur != '0))    w_new = w_cur - 1'b1;
  end

  // Datapath next-state: latching, external writes, per-cycle updates
  always_comb begin
    idx_d = idx_q;
    to_d  = to_q;
    ti_d  = ti_q;
    w_d   = w_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_hit) w_d[wr_sel] = wr_val;
        if (start) begin
          idx_d = '0;
          to_d  = out_time;
          for (int i = 0; i < NSYN; i++) ti_d[i] = in_time[i*TBITS +: TBITS];
        end
      end
      ST_UPDATE: begin
        w_d[idx_q] = w_new;
        idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      to_q  <= NO_SPIKE;
      for (int i = 0; i < NSYN; i++) begin
        ti_q[i] <= NO_SPIKE;
        w_q[i]  <= INIT_W_C;
      end
    end else begin
      idx_q <= idx_d;
      to_q  <= to_d;
      ti_q  <= ti_d;
      w_q   <= w_d;
    end
  end

  generate
    for (genvar g = 0; g < NSYN; g++) begin : g_pack
      assign weights[g*WBITS +: WBITS] = w_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stdp_rand_update.sv
`default_nettype none
// Directed self-checking bench for stdp_rand_update (NSYN=8, WBITS=3, TBITS=4, INIT_W=3).
module tb_stdp_rand_update;

  localparam int NSYN = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in_time;
  logic [3:0]  out_time;
  logic [15:0] rnd, mu_capture, mu_backoff, mu_search;
  logic        busy, done;
  logic [23:0] weights;
`ifdef STDP_WEIGHT_LOAD_EN
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [2:0]  wr_data;
`endif

  int checks;
  int failures;

  stdp_rand_update #(.NSYN(8), .WBITS(3), .TBITS(4), .INIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_time(in_time), .out_time(out_time), .rnd(rnd),
    .mu_capture(mu_capture), .mu_backoff(mu_backoff), .mu_search(mu_search),
    .busy(busy), .done(done), .weights(weights)
`ifdef STDP_WEIGHT_LOAD_EN
    , .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] all_w(input logic [2:0] v);
    return {8{v}};
  endfunction

  function automatic logic [31:0] all_t(input logic [3:0] v);
    return {8{v}};
  endfunction

  // One full pass with exact timing; done must be high right after edge k+NSYN.
  task automatic do_pass(input string tag);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (NSYN) tick;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: got done=%b want 1", tag, done);
    end
    tick;
  endtask

  task automatic test_reset;
    logic [23:0] w0;
    rst_n = 1'b0;
    repeat (3) tick;
    checks++;
    if (weights !== all_w(3'd3) || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got w=%h busy=%b done=%b want w=%h busy=0 done=0",
               weights, busy, done, all_w(3'd3));
    end
    rst_n = 1'b1;
    tick;
    w0 = weights;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (weights !== all_w(3'd3) || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold[%0d]: got w=%h busy=%b done=%b want w=%h", i, weights, busy, done, all_w(3'd3));
      end
    end
    if (w0 !== all_w(3'd3)) begin
      checks++;
      failures++;
      $display("FAIL reset_release: got w=%h want %h", w0, all_w(3'd3));
    end
  endtask

  // Walks a pass edge by edge; fire=1 means every synapse steps 3->4 (or from base up by 1).
  task automatic test_capture_pass(input logic [2:0] base, input logic fire, input string tag);
    logic [23:0] exp;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || weights !== all_w(base)) begin
      failures++;
      $display("FAIL %s_edge_k: got busy=%b done=%b w=%h want busy=1 done=0 w=%h", tag, busy, done, weights, all_w(base));
    end
    for (int i = 0; i < NSYN; i++) begin
      tick;
      exp = all_w(base);
      if (fire) for (int j = 0; j <= i; j++) exp[j*3 +: 3] = base + 3'd1;
      checks++;
      if (weights !== exp || busy !== 1'b1 || done !== (i == NSYN - 1)) begin
        failures++;
        $display("FAIL %s_edge_k+%0d: got w=%h busy=%b done=%b want w=%h busy=1 done=%b",
                 tag, i + 1, weights, busy, done, exp, (i == NSYN - 1));
      end
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: got busy=%b done=%b want 0 0", tag, busy, done);
    end
  endtask

  task automatic test_saturation;
    for (int p = 0; p < 6; p++) begin
      do_pass("sat_up");
      checks++;
      if (weights !== all_w((p < 3) ? 3'(5 + p) : 3'd7)) begin
        failures++;
        $display("FAIL sat_up[%0d]: got w=%h want %h", p, weights, all_w((p < 3) ? 3'(5 + p) : 3'd7));
      end
    end
    in_time = all_t(4'hF);
    out_time = 4'hF;
    do_pass("nospike");
    checks++;
    if (weights !== all_w(3'd7)) begin
      failures++;
      $display("FAIL nospike_hold: got w=%h want %h", weights, all_w(3'd7));
    end
    out_time = 4'd0;
    mu_backoff = 16'hFFFF;
    for (int p = 0; p < 8; p++) begin
      do_pass("sat_down");
      checks++;
      if (weights !== all_w((p < 7) ? 3'(6 - p) : 3'd0)) begin
        failures++;
        $display("FAIL sat_down[%0d]: got w=%h want %h", p, weights, all_w((p < 7) ? 3'(6 - p) : 3'd0));
      end
    end
  endtask

  task automatic test_bernoulli_edges;
    in_time = all_t(4'd1);
    out_time = 4'd2;
    mu_capture = 16'hFFFF;
    rnd = 16'hFFFF;
    do_pass("mu_max_rnd_max");
    checks++;
    if (weights !== all_w(3'd0)) begin
      failures++;
      $display("FAIL mu_max_rnd_max: got w=%h want %h", weights, all_w(3'd0));
    end
    mu_capture = 16'h0000;
    rnd = 16'h0000;
    do_pass("mu_zero");
    checks++;
    if (weights !== all_w(3'd0)) begin
      failures++;
      $display("FAIL mu_zero: got w=%h want %h", weights, all_w(3'd0));
    end
    mu_capture = 16'h0001;
    do_pass("mu_one");
    checks++;
    if (weights !== all_w(3'd1)) begin
      failures++;
      $display("FAIL mu_one: got w=%h want %h", weights, all_w(3'd1));
    end
  endtask

  task automatic test_mixed;
    logic [23:0] exp;
    in_time = 32'h9F2F_F50F;
    out_time = 4'hF;
    mu_search = 16'hFFFF;
    mu_capture = 16'h0000;
    rnd = 16'h0001;
    start = 1'b1;
    tick;
    start = 1'b0;
    in_time = all_t(4'hF);
    out_time = 4'd0;
    mu_backoff = 16'hFFFF;
    tick;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (NSYN - 3) tick;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL mixed_done: got done=%b want 1", done);
    end
    exp = all_w(3'd1);
    exp[3 +: 3] = 3'd2;
    exp[6 +: 3] = 3'd2;
    exp[15 +: 3] = 3'd2;
    exp[21 +: 3] = 3'd2;
    checks++;
    if (weights !== exp) begin
      failures++;
      $display("FAIL mixed_weights: got w=%h want %h", weights, exp);
    end
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || weights !== exp) begin
      failures++;
      $display("FAIL busy_start_ignored: got busy=%b w=%h want busy=0 w=%h", busy, weights, exp);
    end
  endtask

  task automatic test_reset_mid_pass;
    logic seen_done;
    in_time = all_t(4'd1);
    out_time = 4'd2;
    mu_capture = 16'hFFFF;
    rnd = 16'h0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (weights !== all_w(3'd3) || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got w=%h busy=%b done=%b want w=%h busy=0 done=0", weights, busy, done, all_w(3'd3));
    end
    tick;
    tick;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || weights !== all_w(3'd3)) begin
      failures++;
      $display("FAIL reset_abort: got activity=%b w=%h want 0 w=%h", seen_done, weights, all_w(3'd3));
    end
  endtask

`ifdef STDP_WEIGHT_LOAD_EN
  task automatic test_weight_load;
    logic [23:0] exp;
    wr_en = 1'b1; wr_idx = 3'd2; wr_data = 3'd5;
    tick;
    wr_en = 1'b0;
    exp = all_w(3'd3);
    exp[6 +: 3] = 3'd5;
    checks++;
    if (weights !== exp) begin
      failures++;
      $display("FAIL load_idle: got w=%h want %h", weights, exp);
    end
    in_time = all_t(4'd1); out_time = 4'd2; mu_capture = 16'hFFFF; rnd = 16'h0000;
    wr_en = 1'b1; wr_idx = 3'd0; wr_data = 3'd7; start = 1'b1;
    tick;
    start = 1'b0; wr_idx = 3'd3; wr_data = 3'd0;
    repeat (NSYN) tick;
    wr_en = 1'b0;
    tick;
    exp = all_w(3'd4);
    exp[0 +: 3] = 3'd7;
    exp[6 +: 3] = 3'd6;
    checks++;
    if (weights !== exp || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_busy_drop: got w=%h busy=%b want w=%h busy=0", weights, busy, exp);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_time = all_t(4'hF);
    out_time = 4'hF;
    rnd = 16'h0;
    mu_capture = 16'h0;
    mu_backoff = 16'h0;
    mu_search = 16'h0;
`ifdef STDP_WEIGHT_LOAD_EN
    wr_en = 1'b0; wr_idx = 3'd0; wr_data = 3'd0;
`endif
    test_reset;
    in_time = all_t(4'd1);
    out_time = 4'd2;
    mu_capture = 16'h8000;
    rnd = 16'h1234;
    test_capture_pass(3'd3, 1'b1, "capture");
    rnd = 16'h9000;
    test_capture_pass(3'd4, 1'b0, "no_fire");
    mu_capture = 16'hFFFF;
    rnd = 16'h1234;
    test_saturation;
    test_bernoulli_edges;
    test_mixed;
    test_reset_mid_pass;
`ifdef STDP_WEIGHT_LOAD_EN
    test_weight_load;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
